char_console_ctrl: RTL
======================

# char_console_ctrl

Terminal-style writer that sequences the 80x60 character display RAM through its CPU-side port. Accepts a stream of 7-bit character codes over a valid/ready handshake and maintains a hardware cursor. Printable codes go into RAM at the cursor. Control codes move the cursor, clear the screen, or trigger a hardware scroll, which copies rows 1..59 up one row and blanks row 59. It sits between the CPU/UART character source and the display RAM's write/read port; the VGA read port is untouched.

## Interface
- COLS, 80, glyph columns per row
- ROWS, 60, glyph rows
- CHAR_W, 7, character code width
- ADDR_W, 13, display RAM address width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- char_valid  in  1  char_data is valid
- char_data  in  CHAR_W  character code
- char_ready  out  1  block can accept a code this cycle
- busy  out  1  scroll or clear sequence in progress
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1
- ram_we  out  1  write strobe to display RAM port
- ram_addr  out  ADDR_W  display RAM port address (read and write)
- ram_wdata  out  CHAR_W  write data
- ram_rdata  in  CHAR_W  asynchronous read data at ram_addr

## Operation
- Accept occurs when char_valid && char_ready. char_ready = (state == IDLE).
- Cursor is tracked as (col, row) plus a linear address lin = row*COLS + col, maintained incrementally with no multiplier.
- 0x20..0x7E are printable. In the accept cycle: ram_we=1, ram_addr=lin, ram_wdata=char_data. The cursor then advances.
  - Advance at col 79 wraps to col 0 of the next row.
  - Advance at (79,59) starts SCROLL with the cursor set to (0,59).
- 0x0D (CR): col=0.
- 0x0A (LF): row+1, col unchanged. At row 59, start SCROLL and keep row 59.
- 0x08 (BS): move back one cell and write 0x20 there in the accept cycle, at address lin-1.
  - At col 0 with row>0, move to (79,row-1).
  - At (0,0), no write and no move.
- 0x0C (FF): start CLEAR and home the cursor to (0,0) at the accept edge.
- All other codes (0x00..0x1F not listed, 0x7F) are consumed with no effect.
- States:
  - IDLE
  - SCR_RD: ram_addr = src = dst+COLS; ram_rdata is latched at the edge.
  - SCR_WR: ram_addr = dst, ram_we=1, ram_wdata = latch; then dst+1.
  - SCR_CLR: ram_addr = 4720..4799, ram_we=1, wdata=0x20.
  - CLR: ram_addr = 0..4799, ram_we=1, wdata=0x20.
- Transitions:
  - IDLE -> SCR_RD on a scroll trigger, dst=0.
  - SCR_RD <-> SCR_WR until dst reaches 4719 written; then SCR_CLR.
  - SCR_CLR -> IDLE after address 4799.
  - IDLE -> CLR on FF. CLR -> IDLE after address 4799.
- busy = (state != IDLE). Outside write cycles ram_we=0 and ram_addr=lin.
- Address counters never exceed 4799. No address ≥ CELLS is ever driven.

## Timing
- Reset values:
  - state=IDLE, cursor (0,0), lin=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - busy=0, char_ready=1.
- Printable or BS: the RAM write completes at the accepting edge. The cursor updates at the same edge. Zero extra cycles; back-to-back accepts every cycle are allowed.
- CR/LF without scroll: 1 cycle, ready remains high.
- Scroll: char_ready low from the cycle after accept for exactly 2*4720 + 80 = 9520 cycles, then high.
- Clear: char_ready low for exactly 4800 cycles.
- A printable that wraps into a scroll is written at (79,59) first. The scroll follows, so that character ends up at row 58, col 79.
- char_valid while busy is ignored. The source must hold the code until ready.
- Reset mid-sequence aborts immediately. RAM keeps its partially copied or partially cleared contents, and the cursor returns to (0,0).

## Structure
- Shared package console_pkg holds:
  - COLS, ROWS, CELLS=4800, LAST_ROW_BASE=4720
  - Control codes CR, LF, BS, FF, SPACE
  - The state enum
- Sub-module console_cursor: col/row/lin registers with advance, CR, LF, BS, and home controls. It flags wrap-out-of-row-59 and LF-at-row-59 as scroll_req.
- The top level holds the FSM, copy counters, and read latch.

## Test plan
- Reset, then send 'A','B' (0x41, 0x42) on consecutive cycles -> RAM[0]=0x41, RAM[1]=0x42, cursor (2,0), char_ready never drops.
- 80 printable codes then 'Z' -> RAM[79] holds the 80th code, RAM[80]=0x5A, cursor (1,1).
- Fill RAM[k]=k mod 95 + 0x20, cursor at (0,59), send LF:
  - char_ready low for 9520 cycles.
  - Afterward RAM[i] equals the old RAM[i+80] for i<4720.
  - RAM[4720..4799]=0x20, cursor (0,59).
- BS at (0,1) -> cursor (79,0), RAM[79]=0x20. BS at (0,0) -> no write, cursor unchanged.
- FF with a non-blank screen -> cursor (0,0) at accept, 4800 busy cycles, all cells 0x20. A char_valid held high during busy is accepted only after.
- Assert reset during SCR_WR at dst=1000 -> outputs return to reset values asynchronously, state IDLE, RAM[0..999] shifted, RAM[1001..] unchanged.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM state type for the character console writer.
package console_pkg;

  localparam int COLS          = 80;
  localparam int ROWS          = 60;
  localparam int CHAR_W        = 7;
  localparam int ADDR_W        = 13;
  localparam int CELLS         = COLS * ROWS;       // 4800
  localparam int LAST_ROW_BASE = CELLS - COLS;      // 4720

  localparam logic [CHAR_W-1:0] CR    = 7'h0D;
  localparam logic [CHAR_W-1:0] LF    = 7'h0A;
  localparam logic [CHAR_W-1:0] BS    = 7'h08;
  localparam logic [CHAR_W-1:0] FF    = 7'h0C;
  localparam logic [CHAR_W-1:0] SPACE = 7'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCR_RD,
    S_SCR_WR,
    S_SCR_CLR,
    S_CLR
  } state_t;

  // 0x20..0x7E are written to the screen; everything else is a control or ignored code.
  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position as (col,row) plus the matching linear RAM address, updated without a multiplier.
module console_cursor
  import console_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              cr,
  input  logic              lf,
  input  logic              bs,
  input  logic              home,
  output logic [6:0]        col,
  output logic [5:0]        row,
  output logic [ADDR_W-1:0] lin,
  output logic              scroll_req
);

  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = 13'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = 13'(LAST_ROW_BASE);

  // Leaving the bottom row, by wrap or by line feed, asks the controller to scroll.
  assign scroll_req = (adv && (col == LAST_COL) && (row == LAST_ROW)) ||
                      (lf && (row == LAST_ROW));

  // Cursor registers; the controller asserts at most one command per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      lin <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
      lin <= '0;
    end else if (adv) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (row == LAST_ROW) begin
          lin <= LAST_BASE;               // bottom row stays put; the scroll makes room
        end else begin
          row <= row + 6'd1;
          lin <= lin + 13'd1;             // end of row N + 1 is start of row N+1
        end
      end else begin
        col <= col + 7'd1;
        lin <= lin + 13'd1;
      end
    end else if (cr) begin
      col <= '0;
      lin <= lin - {6'd0, col};
    end else if (lf) begin
      if (row != LAST_ROW) begin
        row <= row + 6'd1;
        lin <= lin + ROW_STEP;
      end
    end else if (bs) begin
      if (col != 7'd0) begin
        col <= col - 7'd1;
        lin <= lin - 13'd1;
      end else if (row != 6'd0) begin
        col <= LAST_COL;
        row <= row - 6'd1;
        lin <= lin - 13'd1;
      end
    end
  end

endmodule

// File: rtl/char_console_ctrl.sv
// Terminal-style writer: takes character codes over valid/ready and sequences the display RAM port.
//
// Handshake: a code is taken on a rising edge where char_valid && char_ready. char_ready is high
// only in IDLE; the source must hold char_data stable until it is taken. Printable and backspace
// writes land on the accepting edge, so codes may be taken on every cycle while idle.
module char_console_ctrl
  import console_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char_data,
  output logic              char_ready,
  output logic              busy,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CHAR_W-1:0] ram_wdata,
  input  logic [CHAR_W-1:0] ram_rdata,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] ROW_STEP  = 13'(COLS);
  localparam logic [ADDR_W-1:0] COPY_LAST = 13'(LAST_ROW_BASE - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = 13'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = 13'(LAST_ROW_BASE);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;      // copy destination / clear address
  logic [CHAR_W-1:0]   rd_latch;
  logic [ADDR_W-1:0]   lin;
  logic                accept, adv, cr, lf, bs, home, scroll_req;

  assign char_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Decode the accepted code into cursor commands; BS at the home cell does nothing.
  assign accept = char_ready && char_valid;
  assign adv    = accept && is_printable(char_data);
  assign cr     = accept && (char_data == CR);
  assign lf     = accept && (char_data == LF);
  assign bs     = accept && (char_data == BS) && (lin != '0);
  assign home   = accept && (char_data == FF);

  console_cursor u_cursor (
    .clk        (clk),
    .reset      (reset),
    .adv        (adv),
    .cr         (cr),
    .lf         (lf),
    .bs         (bs),
    .home       (home),
    .col        (cursor_col),
    .row        (cursor_row),
    .lin        (lin),
    .scroll_req (scroll_req)
  );

  // State, address counter and scroll read latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      rd_latch <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (state == S_SCR_RD) rd_latch <= ram_rdata;
    end
  end

  // Next state and RAM port drive; the port idles at the cursor address with writes off.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ram_we    = 1'b0;
    ram_addr  = lin;
    ram_wdata = '0;
    case (state)
      S_IDLE: begin
        if (adv) begin
          ram_we    = 1'b1;
          ram_wdata = char_data;
        end else if (bs) begin
          ram_we    = 1'b1;
          ram_addr  = lin - 13'd1;
          ram_wdata = SPACE;
        end
        if (home) begin
          state_nxt = S_CLR;
          ptr_nxt   = '0;
        end else if (scroll_req) begin
          state_nxt = S_SCR_RD;
          ptr_nxt   = '0;
        end
      end
      S_SCR_RD: begin
        ram_addr  = ptr + ROW_STEP;       // source cell is one row below the destination
        state_nxt = S_SCR_WR;
      end
      S_SCR_WR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdata = rd_latch;
        if (ptr == COPY_LAST) begin
          ptr_nxt   = LAST_BASE;
          state_nxt = S_SCR_CLR;
        end else begin
          ptr_nxt   = ptr + 13'd1;
          state_nxt = S_SCR_RD;
        end
      end
      S_SCR_CLR, S_CLR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdata = SPACE;
        if (ptr == CELL_LAST) begin
          ptr_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          ptr_nxt = ptr + 13'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
